md_unit: RTL and testbench

//   Multi-cycle multiply/divide unit of the EX stage, owning the HI/LO registers.

---
 rtl/md_unit.sv | 172 +++++++++++++++++
 tb/tb_md_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed at issue into pending registers and committed when the busy window ends.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic        we,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_rdata
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d;
  logic [31:0]       pend_lo_q, pend_lo_d;

  // Arithmetic datapath, evaluated on the live operands at issue time.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] quot_s, rem_s;
  logic        [31:0] quot_u, rem_u;
  logic        [31:0] res_hi, res_lo;
  logic               div_zero, div_ovf;
  logic               is_md_op;

  always_comb begin
    prod_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u   = {32'b0, a} * {32'b0, b};
    div_zero = (b == 32'd0);
    div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    quot_s   = 32'sd0;
    rem_s    = 32'sd0;
    quot_u   = 32'd0;
    rem_u    = 32'd0;
    if (!div_zero && !div_ovf) begin
      quot_s = $signed(a) / $signed(b);
      rem_s  = $signed(a) % $signed(b);
    end
    if (!div_zero) begin
      quot_u = a / b;
      rem_u  = a % b;
    end
  end

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    unique case (md_op)
      OpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OpDiv: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else if (div_ovf) begin
          // Most-negative / -1 overflows; pin the architectural result explicitly.
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OpDivu: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  assign is_md_op = (md_op == OpMult) || (md_op == OpMultu) ||
                    (md_op == OpDiv)  || (md_op == OpDivu);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      StIdle: begin
        if (start && is_md_op) begin
          state_d   = StBusy;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          if ((md_op == OpMult) || (md_op == OpMultu)) begin
            cnt_d = CntW'(MULT_CYCLES - 1);
          end else begin
            cnt_d = CntW'(DIV_CYCLES - 1);
          end
        end else if (!start && we && (md_op == OpMthi)) begin
          hi_d = a;
        end else if (!start && we && (md_op == OpMtlo)) begin
          lo_d = a;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy     = (state_q == StBusy);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_rdata = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, arithmetic corner cases, ignored starts, mt*, reset abort.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  md_op;
  logic        start, we, rd_hi;
  logic        busy;
  logic [31:0] hi, lo, md_rdata;

  int checks   = 0;
  int failures = 0;
  int bcnt;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .md_op   (md_op),
    .start   (start),
    .we      (we),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .md_rdata(md_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns with busy expected high.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    md_op = op;
    a     = av;
    b     = bv;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Counts remaining busy cycles, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    a = '0; b = '0; md_op = '0; start = 1'b0; we = 1'b0; rd_hi = 1'b0;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    // mult -3 * 7
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    wait_idle(bcnt);
    check("mult_busy_len", bcnt, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    // divu 100 / 7 and read mux
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(bcnt);
    check("divu_busy_len", bcnt, 32'd10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    rd_hi = 1'b1; #1;
    check("rdata_hi", md_rdata, 32'd2);
    rd_hi = 1'b0; #1;
    check("rdata_lo", md_rdata, 32'd14);

    // div -7 / 2
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(bcnt);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // div -7 / -2
    issue(3'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    wait_idle(bcnt);
    check("div_nn_lo", lo, 32'd3);
    check("div_nn_hi", hi, 32'hFFFF_FFFF);

    // div by zero
    issue(3'd3, 32'd5, 32'd0);
    wait_idle(bcnt);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd5);

    // divu by zero
    issue(3'd4, 32'h8000_0001, 32'd0);
    wait_idle(bcnt);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h8000_0001);

    // div overflow
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(bcnt);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'd0);

    // mult most-negative squared = 2^62
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    wait_idle(bcnt);
    check("mult_mn_hi", hi, 32'h4000_0000);
    check("mult_mn_lo", lo, 32'd0);

    // multu with a second start during busy cycle 2
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    md_op = 3'd3; a = 32'd5; b = 32'd0; start = 1'b1;
    step();
    start = 1'b0; md_op = 3'd0;
    wait_idle(bcnt);
    check("multu_restart_rem", bcnt, 32'd3);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'd1);

    // mtlo while busy is ignored
    issue(3'd1, 32'd2, 32'd3);
    md_op = 3'd6; a = 32'd1234; we = 1'b1;
    step();
    we = 1'b0; md_op = 3'd0;
    check("mtlo_busy_lo", lo, 32'd1);
    wait_idle(bcnt);
    check("mult23_lo", lo, 32'd6);
    check("mult23_hi", hi, 32'd0);

    // mtlo / mthi in idle
    md_op = 3'd6; a = 32'd1234; we = 1'b1;
    step();
    we = 1'b0; md_op = 3'd0;
    check("mtlo_lo", lo, 32'd1234);
    check("mtlo_hi", hi, 32'd0);
    md_op = 3'd5; a = 32'h0000_ABCD; we = 1'b1;
    step();
    we = 1'b0; md_op = 3'd0;
    check("mthi_hi", hi, 32'h0000_ABCD);
    check("mthi_lo", lo, 32'd1234);

    // mthi with start asserted, and start with op 7: both ignored
    md_op = 3'd5; a = 32'h5555_5555; we = 1'b1; start = 1'b1;
    step();
    we = 1'b0; start = 1'b0;
    check("mthi_start_hi", hi, 32'h0000_ABCD);
    check("start_op5_busy", {31'd0, busy}, 32'd0);
    md_op = 3'd7; start = 1'b1;
    step();
    start = 1'b0; md_op = 3'd0;
    check("start_op7_busy", {31'd0, busy}, 32'd0);

    // reset during busy cycle 3 of mult
    issue(3'd1, 32'hFFFF_FFFD, 32'd7);
    step();
    step();
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    repeat (12) step();
    check("post_abort_busy", {31'd0, busy}, 32'd0);
    check("post_abort_hi", hi, 32'd0);
    check("post_abort_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
